imem_loadable: RTL and testbench

- Parametrised successor to the fixed-content instruction memory.
- Programs are streamed in at run time over a valid/ready load port instead of being hard-coded.
- Fetch port is registered, with alignment and range checking.
- Sits between the program loader (testbench or UART bridge) and the processor IF stage; the processor fetches only when the block reports ready.

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_loadable.sv | 152 +++++++++++++++
 tb/tb_imem_loadable.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: FSM states,
// the FINISH opcode and the default fill word for cleared/unloaded words.
// No logic; imported by imem_loadable.
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } imem_state_t;

  localparam logic [5:0]  FINISH_OPCODE     = 6'b111111;
  localparam logic [31:0] DEFAULT_FILL_WORD = 32'hFC000000;

endpackage

// File: rtl/imem_loadable.sv
// Instruction memory loaded at run time over a valid/ready port; registered fetch
// with alignment/range checking. Fetch latency 1 cycle; load_ready only in LOAD,
// mem_ready only in RUN, so fetch and load never overlap.
// Ports: clk/rst (async, active-high); load_start/load_valid/load_data/load_last ->
// load_ready/load_done/load_count; mem_ready; fetch_en/fetch_pc -> instr/instr_valid/
// fetch_fault. Optional macro IMEM_FINISH_DETECT_EN adds a sticky halt output.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter int                PC_W      = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = DEFAULT_FILL_WORD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  output logic                     load_done,
  output logic [$clog2(DEPTH):0]   load_count,
  output logic                     mem_ready,
  input  logic                     fetch_en,
  input  logic [PC_W-1:0]          fetch_pc,
  output logic [DATA_W-1:0]        instr,
  output logic                     instr_valid,
  output logic                     fetch_fault
`ifdef IMEM_FINISH_DETECT_EN
  ,
  output logic                     halt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  imem_state_t state, state_nxt;
  logic [AW-1:0]     ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic          wr_acc;
  logic          load_end;
  logic [AW-1:0] idx;
  logic          fault;

  assign wr_acc   = load_valid && load_ready;
  // A load ends on an explicit last word or when the array is full.
  assign load_end = wr_acc && (load_last || ptr == LAST_IDX);
  assign idx      = fetch_pc[AW+1:2];
  assign fault    = (fetch_pc[1:0] != 2'b00) || (fetch_pc[PC_W-1:AW+2] != '0);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (ptr == LAST_IDX) state_nxt = RUN;
      RUN:     if (load_start)      state_nxt = LOAD;
      LOAD:    if (load_end)        state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_ready  = 1'b0;
    load_ready = 1'b0;
    case (state)
      RUN:     mem_ready  = 1'b1;
      LOAD:    load_ready = 1'b1;
      default: ;
    endcase
  end

  // Write pointer, load bookkeeping. The pointer wraps to 0 at the end of CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      load_count <= '0;
      load_done  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        CLEAR: ptr <= ptr + AW'(1);
        RUN: if (load_start) begin
          ptr        <= '0;
          load_count <= '0;
        end
        LOAD: if (wr_acc) begin
          ptr        <= ptr + AW'(1);
          load_count <= load_count + 1'b1;
          load_done  <= load_end;
        end
        default: ;
      endcase
    end
  end

  // Storage: no reset so it maps onto distributed RAM; CLEAR provides initial contents.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[ptr] <= FILL_WORD;
    else if (wr_acc)
      mem[ptr] <= load_data;
  end

  // Registered fetch. Outside RUN the request is answered as not-valid and instr holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr       <= FILL_WORD;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      if (fetch_en) begin
        instr_valid <= mem_ready;
        if (!mem_ready) begin
          fetch_fault <= 1'b0;
        end else if (fault) begin
          instr       <= FILL_WORD;
          fetch_fault <= 1'b1;
        end else begin
          instr       <= mem[idx];
          fetch_fault <= 1'b0;
        end
      end
    end
  end

`ifdef IMEM_FINISH_DETECT_EN
  logic halt_q;
  logic halt_hit;

  assign halt_hit = instr_valid && !fetch_fault && (instr[DATA_W-1 -: 6] == FINISH_OPCODE);
  // Visible in the same cycle the FINISH word is presented, then held.
  assign halt     = halt_q || halt_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             halt_q <= 1'b0;
    else if (load_start) halt_q <= 1'b0;
    else if (halt_hit)   halt_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable (DEPTH=16): fetch responses go through an
// expected-value queue checked by an independent monitor; load/reset side
// effects are checked inline.
module tb_imem_loadable;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int PW = 32;
  localparam logic [31:0] FILL = 32'hFC000000;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start, load_valid, load_last;
  logic [DW-1:0] load_data;
  logic          load_ready, load_done, mem_ready;
  logic [4:0]    load_count;
  logic          fetch_en;
  logic [PW-1:0] fetch_pc;
  logic [DW-1:0] instr;
  logic          instr_valid, fetch_fault;
`ifdef IMEM_FINISH_DETECT_EN
  logic          halt;
`endif

  imem_loadable #(.DATA_W(DW), .DEPTH(DEPTH), .PC_W(PW), .FILL_WORD(FILL)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .load_count(load_count), .mem_ready(mem_ready),
    .fetch_en(fetch_en), .fetch_pc(fetch_pc),
    .instr(instr), .instr_valid(instr_valid), .fetch_fault(fetch_fault)
`ifdef IMEM_FINISH_DETECT_EN
    , .halt(halt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic fault; } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every presented fetch result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && instr_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_fetch: instr 0x%08h with no fetch pending", instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("fetch_instr", instr, e.instr);
        check("fetch_fault", {31'b0, fetch_fault}, {31'b0, e.fault});
      end
    end
    if (!rst && load_done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ei, input logic ef);
    exp_t e;
    e.instr = ei; e.fault = ef;
    exp_q.push_back(e);
    fetch_en = 1'b1; fetch_pc = pc;
    tick();
    fetch_en = 1'b0;
    tick();
  endtask

  task automatic wait_run();
    int n = 0;
    while (!mem_ready && n < 100) begin tick(); n++; end
    if (!mem_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_run: mem_ready 0, expected 1 within 100 cycles");
    end
  endtask

  task automatic start_load();
    wait_run();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("load_ready_on_start", {31'b0, load_ready}, 32'd1);
  endtask

  task automatic beat(input logic [31:0] d, input logic v, input logic l);
    load_data = d; load_valid = v; load_last = l;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic check_reset_done();
    repeat (15) tick();
    check("mem_ready_cycle15", {31'b0, mem_ready}, 32'd0);
    tick();
    check("mem_ready_cycle16", {31'b0, mem_ready}, 32'd1);
  endtask

  int d0;

  initial begin
    rst = 1'b1; load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
    fetch_en = 0; fetch_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr", instr, FILL);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_load_ready", {31'b0, load_ready}, 32'd0);
    check("rst_load_count", {27'b0, load_count}, 32'd0);
`ifdef IMEM_FINISH_DETECT_EN
    check("rst_halt", {31'b0, halt}, 32'd0);
`endif
    rst = 1'b0;
    check_reset_done();
    check("clear_load_ready", {31'b0, load_ready}, 32'd0);
    fetch(32'h8, FILL, 1'b0);
`ifdef IMEM_FINISH_DETECT_EN
    check("halt_on_fill", {31'b0, halt}, 32'd1);
`endif

    // Three-word load
    d0 = done_cnt;
    start_load();
    beat(32'h2001000B, 1, 0);
    beat(32'h2022001E, 1, 0);
    beat(32'h00221820, 1, 1);
    check("load3_done_pulse", {31'b0, load_done}, 32'd1);
    tick();
    check("load3_done_low", {31'b0, load_done}, 32'd0);
    check("load3_count", {27'b0, load_count}, 32'd3);
    check("load3_done_once", done_cnt - d0, 32'd1);
    fetch(32'h4, 32'h2022001E, 1'b0);

    // Fetch in the load_start cycle is still serviced; then gapped load
    d0 = done_cnt;
    exp_q.push_back('{instr: 32'h2001000B, fault: 1'b0});
    fetch_en = 1'b1; fetch_pc = 32'h0; load_start = 1'b1;
    tick();
    fetch_en = 1'b0; load_start = 1'b0;
    beat(32'h11111111, 1, 0);
    beat(32'hDEADBEEF, 0, 0);
    beat(32'h22222222, 1, 0);
    beat(32'hDEADBEEF, 0, 0);
    beat(32'h33333333, 1, 1);
    tick();
    check("gap_count", {27'b0, load_count}, 32'd3);
    check("gap_done_once", done_cnt - d0, 32'd1);
    fetch(32'h0, 32'h11111111, 1'b0);
    fetch(32'h4, 32'h22222222, 1'b0);
    fetch(32'h8, 32'h33333333, 1'b0);
    fetch(32'hC, FILL, 1'b0);

    // Faults
    fetch(32'h6, FILL, 1'b1);
    fetch(32'h0, 32'h11111111, 1'b0);
    fetch(32'h40, FILL, 1'b1);

    // Fetch while in LOAD: not valid, fault cleared, instr held
    d0 = done_cnt;
    start_load();
    fetch_en = 1'b1; fetch_pc = 32'h0;
    tick();
    fetch_en = 1'b0;
    check("load_fetch_valid", {31'b0, instr_valid}, 32'd0);
    check("load_fetch_fault", {31'b0, fetch_fault}, 32'd0);
    check("load_fetch_instr", instr, FILL);

    // Truncated load: 17 words offered, 16 accepted
    for (int i = 0; i < 17; i++) begin
      if (i == 16) check("trunc_ready_off", {31'b0, load_ready}, 32'd0);
      beat(32'h10000000 + i, 1, 0);
      if (i == 15) check("trunc_done_pulse", {31'b0, load_done}, 32'd1);
    end
    tick();
    check("trunc_count", {27'b0, load_count}, 32'd16);
    check("trunc_ready_after", {31'b0, load_ready}, 32'd0);
    check("trunc_done_once", done_cnt - d0, 32'd1);
    fetch(32'h3C, 32'h1000000F, 1'b0);
    fetch(32'h0, 32'h10000000, 1'b0);

    // Reset mid-load
    start_load();
    beat(32'hAAAA0001, 1, 0);
    beat(32'hAAAA0002, 1, 0);
    rst = 1'b1;
    #1;
    check("midrst_load_ready", {31'b0, load_ready}, 32'd0);
    check("midrst_load_count", {27'b0, load_count}, 32'd0);
    check("midrst_instr", instr, FILL);
    check("midrst_mem_ready", {31'b0, mem_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_done();
    fetch(32'h0, FILL, 1'b0);
    fetch(32'h4, FILL, 1'b0);

`ifdef IMEM_FINISH_DETECT_EN
    start_load();
    check("halt_cleared", {31'b0, halt}, 32'd0);
    beat(32'h00000001, 1, 0);
    beat(32'hFC000ABC, 1, 1);
    tick();
    fetch(32'h0, 32'h00000001, 1'b0);
    check("halt_not_set", {31'b0, halt}, 32'd0);
    fetch(32'h4, 32'hFC000ABC, 1'b0);
    check("halt_set", {31'b0, halt}, 32'd1);
    repeat (3) tick();
    check("halt_sticky", {31'b0, halt}, 32'd1);
    start_load();
    check("halt_load_clear", {31'b0, halt}, 32'd0);
    beat(32'h0, 1, 1);
    tick();
`endif

    repeat (2) tick();
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL pending_fetches: %0d responses missing, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
